ps2_command_tx: RTL and testbench
=================================

Name: ps2_command_tx

Overview:
- Host-to-device transmitter for the PS/2 port: sends one 8-bit command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard.
- Complements the existing PS/2 receive path. Shares the PS2CLK/PS2DAT open-drain pins, which the top level drives low when the matching `*_oe` output is 1 and otherwise leaves high-impedance.
- Runs on the 50 MHz system clock. Reports completion, missing ACK and timeouts to the keyboard-control logic.

Parameters:
- INHIBIT_CYCLES, 6000: clock-inhibit hold before the request (120 us at 50 MHz).
- START_TIMEOUT_CYCLES, 750000: maximum wait from clock release to the first device falling edge (15 ms).
- XFER_TIMEOUT_CYCLES, 100000: maximum time from the first falling edge to the end of ACK (2 ms).

Ports:
- clk, input, 1: system clock, 50 MHz.
- rst, input, 1: asynchronous reset, active-high.
- the_command, input, 8: byte to send; latched when a request is accepted.
- send_command, input, 1: request strobe; level-sampled, accepted only in IDLE.
- ps2_clk_in, input, 1: PS2CLK pin value, asynchronous.
- ps2_dat_in, input, 1: PS2DAT pin value, asynchronous.
- ps2_clk_oe, output, 1: 1 = pull PS2CLK low.
- ps2_dat_oe, output, 1: 1 = pull PS2DAT low.
- busy, output, 1: high from request acceptance until return to IDLE. The receive path ignores data while busy.
- command_was_sent, output, 1: one-cycle pulse on a successful ACKed transfer.
- error_no_ack, output, 1: one-cycle pulse when the device does not ACK.
- error_communication_timed_out, output, 1: one-cycle pulse on either timeout.

Behaviour:
- Reset (asynchronous, any state):
  - All outputs go to 0. Both oe are 0, so both lines are released immediately.
  - FSM goes to IDLE; counters and the shift register clear.
- Input conditioning:
  - ps2_clk_in and ps2_dat_in each pass through a 2-flop synchroniser.
  - A falling or rising edge of PS2CLK is a change between consecutive synchronised samples.
  - Edge-detect latency is 2–3 clk.
- Parity: odd, computed as the inverted XOR of the_command[7:0]. It is computed at acceptance.
- IDLE:
  - oe outputs are 0 and busy is 0.
  - If send_command=1: latch the_command, set busy=1, go to INHIBIT on the next cycle.
- INHIBIT:
  - ps2_clk_oe=1 for exactly INHIBIT_CYCLES clk.
  - In the final inhibit cycle, ps2_dat_oe is set to 1 (start bit).
  - Next cycle: ps2_clk_oe=0, go to WAIT_FIRST.
- WAIT_FIRST:
  - ps2_dat_oe=1; the start bit is held.
  - Counts cycles. On a PS2CLK falling edge: drive bit0 (ps2_dat_oe = ~bit), set bit index to 1, clear the counter, go to SHIFT.
  - If the count reaches START_TIMEOUT_CYCLES: pulse error_communication_timed_out, go to CLEANUP.
- SHIFT:
  - Each subsequent falling edge drives the next item: falling edges 2–8 drive bits 1–7, edge 9 drives parity, edge 10 drives ps2_dat_oe=0 (stop bit, line released).
  - Data changes only on falling edges; the device samples on rising edges.
  - After edge 10, go to ACK.
- ACK:
  - On falling edge 11, sample PS2DAT. If 0, go to WAIT_RELEASE. If 1, pulse error_no_ack and go to CLEANUP.
- WAIT_RELEASE:
  - When synchronised PS2CLK=1 and PS2DAT=1 (device has released both lines): pulse command_was_sent, set busy=0, go to IDLE.
- XFER timeout:
  - Applies in SHIFT, ACK and WAIT_RELEASE. The counter runs from the first falling edge.
  - On reaching XFER_TIMEOUT_CYCLES: pulse error_communication_timed_out, go to CLEANUP.
  - A timeout takes priority over an edge arriving in the same cycle.
- CLEANUP: one cycle with both oe=0. Next cycle: busy=0, IDLE.
- Pulse exclusivity:
  - Exactly one of command_was_sent, error_no_ack or error_communication_timed_out pulses per accepted request.
  - No pulse occurs without a request.
- Request and data rules:
  - send_command while busy is ignored, and no queueing occurs.
  - send_command held high re-triggers a new transfer on the first IDLE cycle.
  - A the_command change after acceptance has no effect.
- Line-driving rules:
  - ps2_clk_oe and ps2_dat_oe are registered, glitch-free outputs.
  - ps2_clk_oe is never 1 outside INHIBIT.

Test Plan:
- Simulation parameters: INHIBIT_CYCLES=20, START_TIMEOUT_CYCLES=400, XFER_TIMEOUT_CYCLES=1000. The device model clocks at a 40-clk period.
- Send 0xED → clk_oe=1 for 20 cycles; dat low sampled at start; device samples bits 1,0,1,1,0,1,1,1, parity 1, stop 1; model ACKs → one command_was_sent pulse, busy falls after lines are released.
- Send 0x00 / 0xFF / 0x01 → sampled parity 1 / 1 / 0 respectively; command_was_sent each time.
- Device model never clocks → error_communication_timed_out pulses 400 cycles after clock release; both oe=0; busy=0; no other pulse.
- Device stops after 5 falling edges → timeout pulse 1000 cycles after the first edge; lines released.
- Model leaves DATA high at edge 11 → error_no_ack pulse; command_was_sent stays 0.
- rst asserted mid-SHIFT → both oe and busy go 0 asynchronously with no pulses. Then, during a new transfer, send_command=1 with the_command=0x55 → ignored; the original byte completes unchanged.

Source files
------------

// File: rtl/ps2_command_tx.sv
// ---------------------------------------------------------------------------
// ps2_command_tx
//   Host-to-device PS/2 transmitter. Sends one command byte (plus odd parity
//   and stop bit) to the keyboard over the shared open-drain PS2CLK/PS2DAT
//   pins, then checks the device ACK.
//
// Ports
//   clk, rst                      system clock, async active-high reset
//   the_command[7:0]              byte to send, latched on acceptance
//   send_command                  level request, accepted only when idle
//   ps2_clk_in, ps2_dat_in        raw (asynchronous) pin values
//   ps2_clk_oe, ps2_dat_oe        1 = pull the matching pin low
//   busy                          transfer in progress
//   command_was_sent              1-cycle pulse, ACKed transfer
//   error_no_ack                  1-cycle pulse, device did not ACK
//   error_communication_timed_out 1-cycle pulse, start or transfer timeout
// ---------------------------------------------------------------------------
module ps2_command_tx #(
  parameter int INHIBIT_CYCLES       = 6000,
  parameter int START_TIMEOUT_CYCLES = 750000,
  parameter int XFER_TIMEOUT_CYCLES  = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] the_command,
  input  logic       send_command,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       command_was_sent,
  output logic       error_no_ack,
  output logic       error_communication_timed_out
);

  // One shared counter serves inhibit, start wait and transfer windows.
  localparam int MAX_A   = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ?
                           INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
  localparam int MAX_CNT = (MAX_A > XFER_TIMEOUT_CYCLES) ? MAX_A : XFER_TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] INH_START  = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, WAIT_FIRST, SHIFT, ACK, WAIT_RELEASE, CLEANUP
  } state_t;

  // -------------------------------------------------------------------------
  // Pin synchronisers and PS2CLK falling-edge detect
  // -------------------------------------------------------------------------
  logic [1:0] clk_sync, dat_sync;
  logic       clk_prev;
  logic       clk_s, dat_s, clk_fall;

  // Reset to the idle-high line level so leaving reset never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
      clk_prev <= clk_sync[1];
    end
  end

  assign clk_s    = clk_sync[1];
  assign dat_s    = dat_sync[1];
  assign clk_fall = clk_prev & ~clk_s;

  // -------------------------------------------------------------------------
  // Transfer FSM
  // -------------------------------------------------------------------------
  state_t           state;
  logic [8:0]       shreg;    // {parity, byte}, bit 0 goes out first
  logic [3:0]       bit_idx;  // next item to drive on a falling edge
  logic [CNT_W-1:0] cnt;
  logic             xfer_expired;

  assign xfer_expired = (cnt == XFER_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                         <= IDLE;
      shreg                         <= '0;
      bit_idx                       <= '0;
      cnt                           <= '0;
      ps2_clk_oe                    <= 1'b0;
      ps2_dat_oe                    <= 1'b0;
      busy                          <= 1'b0;
      command_was_sent              <= 1'b0;
      error_no_ack                  <= 1'b0;
      error_communication_timed_out <= 1'b0;
    end else begin
      command_was_sent              <= 1'b0;
      error_no_ack                  <= 1'b0;
      error_communication_timed_out <= 1'b0;

      case (state)
        IDLE: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          cnt        <= '0;
          bit_idx    <= '0;
          if (send_command) begin
            // Odd parity: parity bit makes the total count of ones odd.
            shreg      <= {~^the_command, the_command};
            busy       <= 1'b1;
            ps2_clk_oe <= 1'b1;
            // With a single inhibit cycle that cycle is also the last one.
            ps2_dat_oe <= (INHIBIT_CYCLES == 1);
            state      <= INHIBIT;
          end
        end

        // Hold PS2CLK low; raise the start bit in the last inhibit cycle so
        // the request is already formed when the clock is released.
        INHIBIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == INH_START) ps2_dat_oe <= 1'b1;
          if (cnt == INH_LAST) begin
            ps2_clk_oe <= 1'b0;
            cnt        <= '0;
            state      <= WAIT_FIRST;
          end
        end

        WAIT_FIRST: begin
          cnt <= cnt + 1'b1;
          if (cnt == START_LAST) begin
            error_communication_timed_out <= 1'b1;
            ps2_dat_oe                    <= 1'b0;
            state                         <= CLEANUP;
          end else if (clk_fall) begin
            ps2_dat_oe <= ~shreg[0];
            bit_idx    <= 4'd1;
            cnt        <= '0;    // transfer window starts at the first edge
            state      <= SHIFT;
          end
        end

        // Edges 2..8 drive bits 1..7, edge 9 parity, edge 10 the stop bit
        // (line released). The timeout wins over a same-cycle edge.
        SHIFT: begin
          cnt <= cnt + 1'b1;
          if (xfer_expired) begin
            error_communication_timed_out <= 1'b1;
            ps2_dat_oe                    <= 1'b0;
            state                         <= CLEANUP;
          end else if (clk_fall) begin
            if (bit_idx == 4'd9) begin
              ps2_dat_oe <= 1'b0;
              state      <= ACK;
            end else begin
              ps2_dat_oe <= ~shreg[bit_idx];
              bit_idx    <= bit_idx + 4'd1;
            end
          end
        end

        ACK: begin
          cnt <= cnt + 1'b1;
          if (xfer_expired) begin
            error_communication_timed_out <= 1'b1;
            ps2_dat_oe                    <= 1'b0;
            state                         <= CLEANUP;
          end else if (clk_fall) begin
            if (!dat_s) begin
              state <= WAIT_RELEASE;
            end else begin
              error_no_ack <= 1'b1;
              state        <= CLEANUP;
            end
          end
        end

        // Stay busy until the device lets go of both lines, so the receive
        // path never sees the ACK tail as incoming data.
        WAIT_RELEASE: begin
          cnt <= cnt + 1'b1;
          if (xfer_expired) begin
            error_communication_timed_out <= 1'b1;
            ps2_dat_oe                    <= 1'b0;
            state                         <= CLEANUP;
          end else if (clk_s && dat_s) begin
            command_was_sent <= 1'b1;
            busy             <= 1'b0;
            state            <= IDLE;
          end
        end

        CLEANUP: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_command_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_command_tx
//   Self-checking bench for ps2_command_tx with a behavioural PS/2 device
//   (40-clk bit period) on an open-drain line model. Expected frames come
//   from a bit-list model of the PS/2 host-to-device frame.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_command_tx;

  localparam int INH  = 20;
  localparam int STO  = 400;
  localparam int XTO  = 1000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] the_command = 8'h00;
  logic       send_command = 1'b0;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       busy, command_was_sent, error_no_ack, error_communication_timed_out;

  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;

  // Open-drain wired-AND of host and device pull-downs.
  assign ps2_clk_in = ~ps2_clk_oe & ~dev_clk_low;
  assign ps2_dat_in = ~ps2_dat_oe & ~dev_dat_low;

  ps2_command_tx #(
    .INHIBIT_CYCLES      (INH),
    .START_TIMEOUT_CYCLES(STO),
    .XFER_TIMEOUT_CYCLES (XTO)
  ) dut (
    .clk                          (clk),
    .rst                          (rst),
    .the_command                  (the_command),
    .send_command                 (send_command),
    .ps2_clk_in                   (ps2_clk_in),
    .ps2_dat_in                   (ps2_dat_in),
    .ps2_clk_oe                   (ps2_clk_oe),
    .ps2_dat_oe                   (ps2_dat_oe),
    .busy                         (busy),
    .command_was_sent             (command_was_sent),
    .error_no_ack                 (error_no_ack),
    .error_communication_timed_out(error_communication_timed_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: pulse counts/timestamps and inhibit-window length.
  int   n_sent = 0, n_noack = 0, n_to = 0;
  int   t_to = 0, t_rel = 0;
  int   inh_run = 0, last_inh = 0;
  logic busy_at_sent = 1'b1;
  logic [1:0] lines_at_sent = 2'b00;

  always @(negedge clk) begin
    if (command_was_sent) begin
      n_sent++;
      busy_at_sent  = busy;
      lines_at_sent = {ps2_clk_in, ps2_dat_in};
    end
    if (error_no_ack) n_noack++;
    if (error_communication_timed_out) begin
      n_to++;
      t_to = cyc;
    end
    if (ps2_clk_oe) inh_run++;
    else if (inh_run != 0) begin
      last_inh = inh_run;
      inh_run  = 0;
      t_rel    = cyc;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Frame as the device sees it: start, 8 data bits LSB first, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] cmd);
    logic [10:0] f;
    int ones, v;
    f = '0;
    ones = 0;
    v = int'(cmd);
    for (int i = 0; i < 8; i++) begin
      f[1+i] = (((v >> i) % 2) == 1);
      ones += (v >> i) % 2;
    end
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Device: wait for the inhibit/release, sample start, then generate
  // n_falls clock pulses, sampling data at each rising edge.
  task automatic dev_run(input int n_falls, input bit do_ack,
                         output logic [10:0] frame, output bit ok, output int t_fall1);
    int t;
    frame = '0;
    ok = 1'b1;
    t_fall1 = 0;
    t = 0;
    while (!ps2_clk_oe && t < 100) begin @(negedge clk); t++; end
    if (!ps2_clk_oe) begin ok = 1'b0; return; end
    t = 0;
    while (ps2_clk_oe && t < 100) begin @(negedge clk); t++; end
    if (ps2_clk_oe) begin ok = 1'b0; return; end
    frame[0] = ps2_dat_in;
    repeat ($urandom_range(30, 4)) @(negedge clk);
    for (int k = 1; k <= n_falls; k++) begin
      dev_clk_low = 1'b1;
      if (k == 1) t_fall1 = cyc;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k <= 10) frame[k] = ps2_dat_in;
      if (k == 11) dev_dat_low = 1'b0;
      if (k == 10 && do_ack && n_falls == 11) begin
        repeat (5) @(negedge clk);
        dev_dat_low = 1'b1;
        repeat (HALF - 5) @(negedge clk);
      end else if (k < n_falls) begin
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  task automatic start_request(input logic [7:0] cmd);
    @(negedge clk);
    the_command  = cmd;
    send_command = 1'b1;
    @(negedge clk);
    send_command = 1'b0;
    the_command  = 8'($urandom);
  endtask

  task automatic wait_outcome(input int base, input int limit);
    int t;
    t = 0;
    while ((n_sent + n_noack + n_to) == base && t < limit) begin @(negedge clk); t++; end
    n_checks++;
    if ((n_sent + n_noack + n_to) == base) begin
      n_fail++;
      $display("FAIL outcome_wait: no completion pulse within %0d cycles", limit);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outputs: oe/busy=%b want 000", {ps2_clk_oe, ps2_dat_oe, busy});
    end
    n_checks++;
    if ({command_was_sent, error_no_ack, error_communication_timed_out} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_pulses: got %b want 000",
               {command_was_sent, error_no_ack, error_communication_timed_out});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if ({busy, ps2_clk_oe, ps2_dat_oe} !== 3'b000 || (n_sent + n_noack + n_to) != 0) begin
      n_fail++;
      $display("FAIL idle_no_request: busy/oe=%b pulses=%0d want 000/0",
               {busy, ps2_clk_oe, ps2_dat_oe}, n_sent + n_noack + n_to);
    end
  endtask

  task automatic test_send(input logic [7:0] cmd, input bit chk_par, input bit exp_par);
    logic [10:0] frame, exp;
    bit ok;
    int tf, bs, bn, bt;
    exp = model_frame(cmd);
    bs = n_sent; bn = n_noack; bt = n_to;
    start_request(cmd);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL send_busy_%h: busy=%b want 1", cmd, busy);
    end
    dev_run(11, 1'b1, frame, ok, tf);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_handshake_%h: no inhibit/release seen", cmd);
    end
    wait_outcome(bs + bn + bt, 50);
    n_checks++;
    if (last_inh != INH) begin
      n_fail++;
      $display("FAIL inhibit_len_%h: got %0d want %0d", cmd, last_inh, INH);
    end
    n_checks++;
    if (frame !== exp) begin
      n_fail++;
      $display("FAIL frame_%h: got %b want %b", cmd, frame, exp);
    end
    if (chk_par) begin
      n_checks++;
      if (frame[9] !== exp_par) begin
        n_fail++;
        $display("FAIL parity_%h: got %b want %b", cmd, frame[9], exp_par);
      end
    end
    n_checks++;
    if (n_sent - bs != 1 || n_noack != bn || n_to != bt) begin
      n_fail++;
      $display("FAIL pulses_%h: sent/noack/to=%0d/%0d/%0d want 1/0/0",
               cmd, n_sent - bs, n_noack - bn, n_to - bt);
    end
    n_checks++;
    if (busy_at_sent !== 1'b0 || lines_at_sent !== 2'b11 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL release_%h: busy_at_sent=%b lines=%b busy=%b want 0/11/0",
               cmd, busy_at_sent, lines_at_sent, busy);
    end
  endtask

  task automatic test_parity();
    logic [7:0] r;
    test_send(8'h00, 1'b1, 1'b1);
    test_send(8'hFF, 1'b1, 1'b1);
    test_send(8'h01, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      r = 8'($urandom);
      test_send(r, 1'b0, 1'b0);
    end
  endtask

  task automatic test_start_timeout();
    int bs, bn, bt, d;
    bs = n_sent; bn = n_noack; bt = n_to;
    start_request(8'($urandom));
    wait_outcome(bs + bn + bt, 700);
    d = t_to - t_rel;
    n_checks++;
    if (n_to - bt != 1 || n_sent != bs || n_noack != bn) begin
      n_fail++;
      $display("FAIL start_to_pulses: sent/noack/to=%0d/%0d/%0d want 0/0/1",
               n_sent - bs, n_noack - bn, n_to - bt);
    end
    n_checks++;
    if (d < STO - 1 || d > STO + 2) begin
      n_fail++;
      $display("FAIL start_to_delay: got %0d want %0d..%0d", d, STO - 1, STO + 2);
    end
    n_checks++;
    if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL start_to_release: oe/busy=%b want 000", {ps2_clk_oe, ps2_dat_oe, busy});
    end
  endtask

  task automatic test_xfer_timeout();
    logic [10:0] frame;
    bit ok;
    int tf, bs, bn, bt, d;
    bs = n_sent; bn = n_noack; bt = n_to;
    start_request(8'($urandom));
    dev_run(5, 1'b0, frame, ok, tf);
    wait_outcome(bs + bn + bt, 1200);
    d = t_to - tf;
    n_checks++;
    if (n_to - bt != 1 || n_sent != bs || n_noack != bn) begin
      n_fail++;
      $display("FAIL xfer_to_pulses: sent/noack/to=%0d/%0d/%0d want 0/0/1",
               n_sent - bs, n_noack - bn, n_to - bt);
    end
    n_checks++;
    if (d < XTO || d > XTO + 6) begin
      n_fail++;
      $display("FAIL xfer_to_delay: got %0d want %0d..%0d", d, XTO, XTO + 6);
    end
    n_checks++;
    if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL xfer_to_release: oe/busy=%b want 000", {ps2_clk_oe, ps2_dat_oe, busy});
    end
  endtask

  task automatic test_no_ack();
    logic [10:0] frame;
    bit ok;
    int tf, bs, bn, bt;
    bs = n_sent; bn = n_noack; bt = n_to;
    start_request(8'($urandom));
    dev_run(11, 1'b0, frame, ok, tf);
    wait_outcome(bs + bn + bt, 50);
    n_checks++;
    if (n_noack - bn != 1 || n_sent != bs || n_to != bt) begin
      n_fail++;
      $display("FAIL no_ack_pulses: sent/noack/to=%0d/%0d/%0d want 0/1/0",
               n_sent - bs, n_noack - bn, n_to - bt);
    end
    n_checks++;
    if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL no_ack_release: oe/busy=%b want 000", {ps2_clk_oe, ps2_dat_oe, busy});
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [10:0] frame;
    bit ok;
    int tf, base;
    base = n_sent + n_noack + n_to;
    // Bit 3 of 0xA5 is 0, so the host is pulling DATA low after edge 4.
    start_request(8'hA5);
    dev_run(4, 1'b0, frame, ok, tf);
    repeat (5) @(negedge clk);
    n_checks++;
    if ({ps2_dat_oe, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_shift_pre: dat_oe/busy=%b want 11", {ps2_dat_oe, busy});
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset: oe/busy=%b want 000", {ps2_clk_oe, ps2_dat_oe, busy});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    n_checks++;
    if ((n_sent + n_noack + n_to) != base || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_pulse: pulses=%0d busy=%b want 0/0",
               n_sent + n_noack + n_to - base, busy);
    end
  endtask

  task automatic test_ignore_busy();
    logic [10:0] frame;
    logic [7:0]  orig;
    bit ok;
    int tf, bs, bn, bt;
    orig = 8'($urandom);
    if (orig == 8'h55) orig = 8'h3C;
    bs = n_sent; bn = n_noack; bt = n_to;
    start_request(orig);
    fork
      dev_run(11, 1'b1, frame, ok, tf);
      begin
        repeat (60) @(negedge clk);
        the_command  = 8'h55;
        send_command = 1'b1;
        repeat (40) @(negedge clk);
        send_command = 1'b0;
      end
    join
    wait_outcome(bs + bn + bt, 50);
    repeat (40) @(negedge clk);
    n_checks++;
    if (frame !== model_frame(orig)) begin
      n_fail++;
      $display("FAIL busy_ignore_frame: got %b want %b", frame, model_frame(orig));
    end
    n_checks++;
    if (n_sent - bs != 1 || n_noack != bn || n_to != bt || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ignore_pulses: sent/noack/to=%0d/%0d/%0d busy=%b want 1/0/0/0",
               n_sent - bs, n_noack - bn, n_to - bt, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] fa, fb;
    logic [7:0]  a, b;
    bit oka, okb;
    int tf, bs, bn, bt;
    a = 8'($urandom);
    b = 8'($urandom);
    bs = n_sent; bn = n_noack; bt = n_to;
    @(negedge clk);
    the_command  = a;
    send_command = 1'b1;
    @(negedge clk);
    the_command  = b;
    fork
      begin
        dev_run(11, 1'b1, fa, oka, tf);
        dev_run(11, 1'b1, fb, okb, tf);
      end
      begin
        int t;
        t = 0;
        while (n_sent == bs && t < 2000) begin @(negedge clk); t++; end
        t = 0;
        while (!ps2_clk_oe && t < 50) begin @(negedge clk); t++; end
        send_command = 1'b0;
      end
    join
    wait_outcome(bs + 1 + bn + bt, 50);
    n_checks++;
    if (fa !== model_frame(a) || fb !== model_frame(b)) begin
      n_fail++;
      $display("FAIL back_to_back_frames: got %b/%b want %b/%b",
               fa, fb, model_frame(a), model_frame(b));
    end
    n_checks++;
    if (n_sent - bs != 2 || n_noack != bn || n_to != bt || !oka || !okb) begin
      n_fail++;
      $display("FAIL back_to_back_pulses: sent/noack/to=%0d/%0d/%0d want 2/0/0",
               n_sent - bs, n_noack - bn, n_to - bt);
    end
  endtask

  initial begin
    test_reset();
    test_send(8'hED, 1'b1, 1'b1);
    test_parity();
    test_start_timeout();
    test_xfer_timeout();
    test_no_ack();
    test_reset_mid_shift();
    test_ignore_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute backstop so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
